// File: rtl/tdc_power_sequencer.sv
// -----------------------------------------------------------------------------
// tdc_power_sequencer
//
// Power-up and soft-reset sequencer for N_CH TDC front-ends, controlled by
// UART command bytes. After reset it holds the TDC enable low for OFF_CYCLES,
// then raises it and waits BOOT_CYCLES for the TDCs to boot. Next it drives a
// RST_PULSE_CYCLES soft-reset pulse on the channels selected by ch_mask, and
// finally reports ready. It also holds the go_home and pause level flags
// that the motion and readout blocks consume.
//
// Command bytes (decoded only while no mask byte is expected):
//   "d" power-cycle from any state    "r" re-pulse soft reset (READY only)
//   "h"/"c" set/clear go_home         "s"/"p" set/clear pause
//   "m" the next strobed byte is taken raw as the channel mask
//
// Ports
//   clk          in   1     clock
//   rst          in   1     synchronous, active-high reset
//   rx_data      in   8     UART byte, valid only with new_rx_data
//   new_rx_data  in   1     one-cycle strobe: rx_data holds a new byte
//   tdc_enable   out  N_CH  TDC enable, all bits identical, registered
//   soft_reset   out  N_CH  soft-reset pulse gated per channel by ch_mask
//   ready        out  1     sequence complete, TDCs usable
//   go_home      out  1     request motion home (level)
//   pause        out  1     pause acquisition (level)
//   ch_mask      out  N_CH  current soft-reset channel mask
// -----------------------------------------------------------------------------
module tdc_power_sequencer #(
  parameter int N_CH             = 6,
  parameter int OFF_CYCLES       = 1000,
  parameter int BOOT_CYCLES      = 2000000,
  parameter int RST_PULSE_CYCLES = 4,
  parameter int CNT_W            = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            new_rx_data,
  output logic [N_CH-1:0] tdc_enable,
  output logic [N_CH-1:0] soft_reset,
  output logic            ready,
  output logic            go_home,
  output logic            pause,
  output logic [N_CH-1:0] ch_mask
);

  typedef enum logic [1:0] {
    S_OFF,
    S_BOOT,
    S_SRST,
    S_READY
  } state_t;

  localparam logic [7:0] CMD_DOWN       = 8'h64;  // "d"
  localparam logic [7:0] CMD_REPULSE    = 8'h72;  // "r"
  localparam logic [7:0] CMD_HOME_SET   = 8'h68;  // "h"
  localparam logic [7:0] CMD_HOME_CLR   = 8'h63;  // "c"
  localparam logic [7:0] CMD_PAUSE_SET  = 8'h73;  // "s"
  localparam logic [7:0] CMD_PAUSE_CLR  = 8'h70;  // "p"
  localparam logic [7:0] CMD_MASK       = 8'h6D;  // "m"

  // The counter starts at 0 on every state entry, so a phase of N cycles
  // ends when the counter reaches N-1.
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic             mask_pending;
  logic             mask_pending_next;
  logic [N_CH-1:0]  mask_next;
  logic             go_home_next;
  logic             pause_next;
  logic [N_CH-1:0]  tdc_enable_next;
  logic [N_CH-1:0]  soft_reset_next;
  logic             ready_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_OFF;
      counter      <= '0;
      mask_pending <= 1'b0;
      ch_mask      <= '1;
      go_home      <= 1'b0;
      pause        <= 1'b0;
      tdc_enable   <= '0;
      soft_reset   <= '0;
      ready        <= 1'b0;
    end else begin
      state        <= state_next;
      counter      <= counter_next;
      mask_pending <= mask_pending_next;
      ch_mask      <= mask_next;
      go_home      <= go_home_next;
      pause        <= pause_next;
      tdc_enable   <= tdc_enable_next;
      soft_reset   <= soft_reset_next;
      ready        <= ready_next;
    end
  end

  // Phase timing first, then command decode, so that a command byte
  // overrides a phase transition landing in the same cycle. Outputs are
  // derived from the next state and next mask, which lets the registered
  // outputs line up exactly with the state they describe.
  always_comb begin
    state_next        = state;
    counter_next      = counter + CNT_W'(1);
    mask_pending_next = mask_pending;
    mask_next         = ch_mask;
    go_home_next      = go_home;
    pause_next        = pause;

    case (state)
      S_OFF: begin
        if (counter == OFF_LAST) begin
          state_next   = S_BOOT;
          counter_next = '0;
        end
      end
      S_BOOT: begin
        if (counter == BOOT_LAST) begin
          state_next   = S_SRST;
          counter_next = '0;
        end
      end
      S_SRST: begin
        if (counter == SRST_LAST) begin
          state_next   = S_READY;
          counter_next = '0;
        end
      end
      S_READY: begin
        counter_next = '0;
      end
      default: begin
        state_next   = S_OFF;
        counter_next = '0;
      end
    endcase

    if (new_rx_data) begin
      if (mask_pending) begin
        // Byte following "m" is mask data, never a command.
        mask_next         = rx_data[N_CH-1:0];
        mask_pending_next = 1'b0;
      end else begin
        case (rx_data)
          CMD_DOWN: begin
            state_next   = S_OFF;
            counter_next = '0;
            go_home_next = 1'b0;
          end
          CMD_REPULSE: begin
            if (state == S_READY) begin
              state_next   = S_SRST;
              counter_next = '0;
            end
          end
          CMD_HOME_SET:  go_home_next      = 1'b1;
          CMD_HOME_CLR:  go_home_next      = 1'b0;
          CMD_PAUSE_SET: pause_next        = 1'b1;
          CMD_PAUSE_CLR: pause_next        = 1'b0;
          CMD_MASK:      mask_pending_next = 1'b1;
          default: ;
        endcase
      end
    end

    tdc_enable_next = {N_CH{state_next != S_OFF}};
    soft_reset_next = (state_next == S_SRST) ? mask_next : '0;
    ready_next      = (state_next == S_READY);
  end

endmodule

// File: tb/tb_tdc_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tdc_power_sequencer
//
// Self-checking bench for tdc_power_sequencer with N_CH=6, OFF=4, BOOT=10,
// RST_PULSE=3. The reference model tracks the time elapsed since the current
// power cycle began; every timed output is a simple range test on that time.
// A compare process checks all outputs against the model on each falling
// edge, and directed scenarios add literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_tdc_power_sequencer;

  localparam int N_CH  = 6;
  localparam int OFF   = 4;
  localparam int BOOT  = 10;
  localparam int PULSE = 3;

  logic            clk;
  logic            rst;
  logic [7:0]      rx_data;
  logic            new_rx_data;
  logic [N_CH-1:0] tdc_enable;
  logic [N_CH-1:0] soft_reset;
  logic            ready;
  logic            go_home;
  logic            pause;
  logic [N_CH-1:0] ch_mask;

  tdc_power_sequencer #(
    .N_CH             (N_CH),
    .OFF_CYCLES       (OFF),
    .BOOT_CYCLES      (BOOT),
    .RST_PULSE_CYCLES (PULSE),
    .CNT_W            (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tdc_enable  (tdc_enable),
    .soft_reset  (soft_reset),
    .ready       (ready),
    .go_home     (go_home),
    .pause       (pause),
    .ch_mask     (ch_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Reference model: m_t is the number of cycles since the power cycle
  // started (0 while in reset or on the cycle after "d").
  int              m_t       = 0;
  logic [N_CH-1:0] m_mask    = '1;
  bit              m_pending = 1'b0;
  bit              m_home    = 1'b0;
  bit              m_pause   = 1'b0;

  function automatic logic [N_CH-1:0] exp_enable();
    return (m_t >= OFF) ? 6'h3F : 6'h00;
  endfunction

  function automatic logic [N_CH-1:0] exp_soft_reset();
    if (m_t >= OFF + BOOT && m_t < OFF + BOOT + PULSE) return m_mask;
    return 6'h00;
  endfunction

  function automatic logic exp_ready();
    return m_t >= OFF + BOOT + PULSE;
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs that edge sampled.
  task automatic update_model(input logic r, input logic s, input logic [7:0] d);
    bit was_ready;
    if (r) begin
      m_t       = 0;
      m_mask    = '1;
      m_pending = 1'b0;
      m_home    = 1'b0;
      m_pause   = 1'b0;
    end else begin
      was_ready = exp_ready();
      m_t++;
      if (s) begin
        if (m_pending) begin
          m_mask    = d[N_CH-1:0];
          m_pending = 1'b0;
        end else begin
          case (d)
            8'h64: begin m_t = 0; m_home = 1'b0; end
            8'h72: if (was_ready) m_t = OFF + BOOT;
            8'h68: m_home    = 1'b1;
            8'h63: m_home    = 1'b0;
            8'h73: m_pause   = 1'b1;
            8'h70: m_pause   = 1'b0;
            8'h6D: m_pending = 1'b1;
            default: ;
          endcase
        end
      end
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and returns at the
  // next falling edge with the model already advanced.
  task automatic apply_stimulus(input logic r, input logic s, input logic [7:0] d);
    rst         = r;
    new_rx_data = s;
    rx_data     = d;
    @(posedge clk);
    update_model(r, s, d);
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    apply_stimulus(1'b0, 1'b1, b);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_output("model tdc_enable", 8'(tdc_enable), 8'(exp_enable()));
      check_output("model soft_reset", 8'(soft_reset), 8'(exp_soft_reset()));
      check_output("model ready",      8'(ready),      8'(exp_ready()));
      check_output("model go_home",    8'(go_home),    8'(m_home));
      check_output("model pause",      8'(pause),      8'(m_pause));
      check_output("model ch_mask",    8'(ch_mask),    8'(m_mask));
    end
  end

  initial begin
    rst         = 1'b1;
    new_rx_data = 1'b0;
    rx_data     = 8'h00;

    // 1. Reset and full power-up sequence.
    $display("[TB] scenario 1: power-up after reset");
    apply_stimulus(1'b1, 1'b0, 8'h00);
    checking = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("reset tdc_enable", 8'(tdc_enable), 8'h00);
    check_output("reset soft_reset", 8'(soft_reset), 8'h00);
    check_output("reset ready",      8'(ready),      8'h00);
    check_output("reset ch_mask",    8'(ch_mask),    8'h3F);
    idle(3);
    check_output("off last cycle enable", 8'(tdc_enable), 8'h00);
    idle(1);
    check_output("enable rise", 8'(tdc_enable), 8'h3F);
    idle(9);
    check_output("boot last cycle soft_reset", 8'(soft_reset), 8'h00);
    idle(1);
    check_output("soft_reset rise", 8'(soft_reset), 8'h3F);
    idle(2);
    check_output("pulse last cycle ready", 8'(ready), 8'h00);
    idle(1);
    check_output("ready rise", 8'(ready), 8'h01);
    check_output("soft_reset fall", 8'(soft_reset), 8'h00);

    // 2. Mask 0x05 then re-pulse; unknown byte is ignored.
    $display("[TB] scenario 2: masked re-pulse");
    send(8'h41);
    send(8'h6D);
    send(8'h05);
    send(8'h72);
    check_output("masked pulse", 8'(soft_reset), 8'h05);
    check_output("ready low in pulse", 8'(ready), 8'h00);
    idle(3);
    check_output("ready after re-pulse", 8'(ready), 8'h01);

    // 3. Power-down mid-boot, "r" ignored in BOOT, "d" on last BOOT cycle.
    $display("[TB] scenario 3: power-down during boot");
    send(8'h64);
    idle(4);
    send(8'h72);
    idle(4);
    send(8'h64);
    check_output("d mid-boot enable", 8'(tdc_enable), 8'h00);
    idle(13);
    check_output("boot end no pulse", 8'(soft_reset), 8'h00);
    send(8'h64);
    check_output("d beats boot end enable", 8'(tdc_enable), 8'h00);
    check_output("d beats boot end pulse", 8'(soft_reset), 8'h00);
    idle(17);

    // 4. Flag commands leave the FSM alone.
    $display("[TB] scenario 4: go_home / pause flags");
    send(8'h68);
    check_output("go_home set", 8'(go_home), 8'h01);
    send(8'h73);
    check_output("pause set", 8'(pause), 8'h01);
    send(8'h70);
    check_output("pause clear", 8'(pause), 8'h00);
    send(8'h63);
    check_output("go_home clear", 8'(go_home), 8'h00);
    check_output("ready kept", 8'(ready), 8'h01);

    // 5. "d" as mask data, mask change mid-pulse, zero mask.
    $display("[TB] scenario 5: mask byte handling");
    send(8'h6D);
    send(8'h64);
    check_output("raw mask 0x64", 8'(ch_mask), 8'h24);
    check_output("no power cycle", 8'(tdc_enable), 8'h3F);
    send(8'h72);
    check_output("pulse mask 0x24", 8'(soft_reset), 8'h24);
    send(8'h6D);
    send(8'h3F);
    check_output("mask change mid-pulse", 8'(soft_reset), 8'h3F);
    idle(1);
    send(8'h6D);
    send(8'h00);
    send(8'h72);
    check_output("zero mask pulse", 8'(soft_reset), 8'h00);
    idle(2);
    check_output("zero mask still pulsing", 8'(ready), 8'h00);
    idle(1);
    check_output("zero mask ready", 8'(ready), 8'h01);

    // 6. Reset during the soft-reset pulse.
    $display("[TB] scenario 6: reset mid-pulse");
    send(8'h6D);
    send(8'h12);
    send(8'h68);
    send(8'h73);
    send(8'h72);
    idle(1);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("rst ch_mask",    8'(ch_mask),    8'h3F);
    check_output("rst go_home",    8'(go_home),    8'h00);
    check_output("rst pause",      8'(pause),      8'h00);
    check_output("rst soft_reset", 8'(soft_reset), 8'h00);
    check_output("rst tdc_enable", 8'(tdc_enable), 8'h00);
    idle(14);
    check_output("replay pulse", 8'(soft_reset), 8'h3F);
    idle(3);
    check_output("replay ready", 8'(ready), 8'h01);
    idle(2);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
